fp_div_seq: RTL
===============

// Module: fp_div_seq
// PURPOSE
//  Sequencing initiator for single-precision division q = a / b. Accepts a request, drives the
//  start/done reciprocal unit with b, multiplies a by the returned 1/b, and returns q. Sits between
//  the FPU issue stage and the reciprocal unit; the reciprocal unit is the responder, this block the requester.
// PARAMETERS
//  TAG_W          5   width of the destination-register tag carried with each request
//  TIMEOUT_CYCLES 64  max cycles in WAIT for recip_done before a timeout result is forced
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      reset, asynchronous, active-low
//  req_valid    in   1      request present
//  req_ready    out  1      block can accept (1 only in IDLE)
//  req_a        in   32     dividend, IEEE 754 single
//  req_b        in   32     divisor, IEEE 754 single
//  req_tag      in   TAG_W  tag returned with result
//  flush        in   1      abort in-flight request (pipeline kill)
//  recip_start  out  1      one-cycle start pulse to reciprocal unit
//  recip_b      out  32     divisor to reciprocal unit, held stable from ISSUE until done
//  recip_inv    in   32     1/b from reciprocal unit, valid when recip_done=1
//  recip_done   in   1      reciprocal done level; stays high until next start
//  resp_valid   out  1      result present
//  resp_ready   in   1      consumer accepts result
//  resp_q       out  32     quotient, IEEE 754 single
//  resp_tag     out  TAG_W  tag of the result
//  resp_flags   out  3      {NV invalid, DZ divide-by-zero, TO timeout}
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 after reset; recip_start=0; recip_b=0; resp_valid=0; resp_q=0;
//   resp_tag=0; resp_flags=0; timeout counter=0. Reset mid-operation discards everything.
//  States: IDLE, ISSUE, WAIT, MUL, RESP, DRAIN.
//  IDLE: on req_valid&req_ready capture a, b, tag. Special operand -> RESP next cycle (latency 1),
//   reciprocal unit untouched. Otherwise -> ISSUE.
//  Special cases (sign s = a[31]^b[31]), priority top-down:
//   a or b NaN                  -> 32'h7FC00000, NV=1 only if either is signalling NaN
//   a,b both Inf or both zero   -> 32'h7FC00000, NV=1
//   a Inf                       -> {s,8'hFF,23'h0}
//   b zero (a finite)           -> {s,8'hFF,23'h0}, DZ=1
//   b Inf or a zero             -> {s,31'h0}
//   Denormal operands flushed to signed zero before classification.
//  ISSUE: recip_start=1 for exactly one cycle, recip_b=b (registered); -> WAIT, counter cleared.
//   recip_done during ISSUE is stale from previous op and is ignored.
//  WAIT: sample recip_done each cycle; on 1 latch recip_inv -> MUL. Counter increments; when it reaches
//   TIMEOUT_CYCLES-1 without done -> RESP with q=32'h7FC00000, TO=1, then DRAIN-equivalent guard:
//   next request not accepted until recip_done seen high (go DRAIN after RESP handshake).
//  MUL: resp_q <= FP_Mul(a, inv) with sign forced to s; flags=0; -> RESP. Normal-path latency
//   from accept to resp_valid = 3 + reciprocal latency (cycles spent in WAIT).
//  RESP: resp_valid=1; q/tag/flags held stable while resp_valid&!resp_ready. On resp_ready -> IDLE
//   (or DRAIN after timeout). resp_valid and req_ready never both 1.
//  flush: IDLE/ISSUE-before-edge/RESP -> drop, resp_valid=0, -> IDLE. flush in ISSUE/WAIT/MUL after a
//   start was issued -> DRAIN (responder cannot be aborted). flush and req_valid same cycle in IDLE:
//   flush wins, nothing accepted.
//  DRAIN: req_ready=0; wait for recip_done=1, discard recip_inv, -> IDLE. No response produced.
//  Only one request in flight; no back-to-back overlap with reciprocal unit.
// STRUCTURE
//  Shared package fpu_pkg: QNAN_CANON=32'h7FC00000, POS_INF, flag bit indices NV/DZ/TO,
//   class-decode function (is_nan, is_snan, is_inf, is_zero, is_denorm).
//  One sub-module: existing combinational FP_Mul instance for a*inv; FSM, counter, special-case mux local.
// TESTING
//  a=3F800000(1.0), b=40000000(2.0), responder done after 7 cycles -> one start pulse, q=3F000000, flags=0.
//  a=40C00000(6.0), b=40400000(3.0), resp_ready low 5 cycles -> q=40000000 held stable, tag unchanged.
//  b=00000000, a=BF800000 -> resp_valid 1 cycle after accept, q=FF800000, DZ=1, recip_start never asserted.
//  a=0, b=0 -> 7FC00000 NV=1; a=7F800000,b=7F800000 -> 7FC00000 NV=1; a=7FA00000 (sNaN) -> NV=1.
//  Responder never asserts done -> after 64 WAIT cycles q=7FC00000 TO=1; next req_ready only after done.
//  flush during WAIT, done arrives 3 cycles later -> no resp_valid, req_ready returns after done; reset_n
//   low mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU constants, flag positions, divider FSM states and an IEEE-754 single class decoder.
package fpu_pkg;

  localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;

  // Bit positions within the 3-bit {NV, DZ, TO} flag vector.
  localparam int unsigned FLAG_NV = 2;
  localparam int unsigned FLAG_DZ = 1;
  localparam int unsigned FLAG_TO = 0;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_inf;
    logic is_zero;
    logic is_denorm;
  } fp_class_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StMul,
    StResp,
    StDrain
  } div_state_e;

  function automatic fp_class_t fp_classify(input logic [31:0] x);
    fp_class_t c;
    logic exp_ones, exp_zero, man_zero;
    exp_ones    = &x[30:23];
    exp_zero    = ~|x[30:23];
    man_zero    = ~|x[22:0];
    c.is_nan    = exp_ones & ~man_zero;
    c.is_snan   = exp_ones & ~man_zero & ~x[22];
    c.is_inf    = exp_ones & man_zero;
    c.is_zero   = exp_zero & man_zero;
    c.is_denorm = exp_zero & ~man_zero;
    return c;
  endfunction

endpackage

// File: rtl/fp_div_seq_mul.sv
// Combinational single-precision multiplier: round-to-nearest-even, denormals flushed to zero.
module fp_div_seq_mul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic        sign;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] prod;
  logic [22:0] man, man_rnd;
  logic        guard, sticky, carry;
  logic [9:0]  e_sum;

  always_comb begin
    sign   = a_i[31] ^ b_i[31];
    a_nan  = (&a_i[30:23]) & (|a_i[22:0]);
    b_nan  = (&b_i[30:23]) & (|b_i[22:0]);
    a_inf  = (&a_i[30:23]) & ~(|a_i[22:0]);
    b_inf  = (&b_i[30:23]) & ~(|b_i[22:0]);
    a_zero = ~|a_i[30:23];
    b_zero = ~|b_i[30:23];

    prod = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    if (prod[47]) begin
      man    = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      man    = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    {carry, man_rnd} = {1'b0, man} + {23'b0, guard & (sticky | man[0])};

    // Biased sum still carries one extra bias of 127; 382 = 255 + 127.
    e_sum = {2'b0, a_i[30:23]} + {2'b0, b_i[30:23]} + {9'b0, prod[47]} + {9'b0, carry};

    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      p_o = fpu_pkg::QNAN_CANON;
    end else if (a_inf || b_inf) begin
      p_o = {sign, fpu_pkg::POS_INF[30:0]};
    end else if (a_zero || b_zero) begin
      p_o = {sign, 31'h0};
    end else if (e_sum >= 10'd382) begin
      p_o = {sign, fpu_pkg::POS_INF[30:0]};
    end else if (e_sum <= 10'd127) begin
      p_o = {sign, 31'h0};
    end else begin
      p_o = {sign, 8'(e_sum - 10'd127), man_rnd};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Division sequencer q = a / b: special operands resolved locally, otherwise 1/b is fetched from
// the reciprocal unit and multiplied by a.
module fp_div_seq
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             recip_start,
  output logic [31:0]      recip_b,
  input  logic [31:0]      recip_inv,
  input  logic             recip_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_q,
  output logic [TAG_W-1:0] resp_tag,
  output logic [2:0]       resp_flags
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [31:0]      a_q, a_d, inv_q, inv_d, recip_b_q, recip_b_d, q_q, q_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       flags_q, flags_d;
  logic             sign_q, sign_d, to_q, to_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  fp_class_t   ca, cb;
  logic        a_zero, b_zero, req_sign, spec_hit;
  logic [31:0] spec_q, mul_p;
  logic [2:0]  spec_flags;

  always_comb begin
    ca         = fp_classify(req_a);
    cb         = fp_classify(req_b);
    a_zero     = ca.is_zero | ca.is_denorm;
    b_zero     = cb.is_zero | cb.is_denorm;
    req_sign   = req_a[31] ^ req_b[31];
    spec_hit   = 1'b1;
    spec_q     = QNAN_CANON;
    spec_flags = '0;
    if (ca.is_nan || cb.is_nan) begin
      spec_flags[FLAG_NV] = ca.is_snan | cb.is_snan;
    end else if ((ca.is_inf && cb.is_inf) || (a_zero && b_zero)) begin
      spec_flags[FLAG_NV] = 1'b1;
    end else if (ca.is_inf) begin
      spec_q = {req_sign, POS_INF[30:0]};
    end else if (b_zero) begin
      spec_q              = {req_sign, POS_INF[30:0]};
      spec_flags[FLAG_DZ] = 1'b1;
    end else if (cb.is_inf || a_zero) begin
      spec_q = {req_sign, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  fp_div_seq_mul u_mul (
    .a_i (a_q),
    .b_i (inv_q),
    .p_o (mul_p)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    inv_d     = inv_q;
    recip_b_d = recip_b_q;
    q_d       = q_q;
    tag_d     = tag_q;
    flags_d   = flags_q;
    sign_d    = sign_q;
    to_d      = to_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          tag_d  = req_tag;
          sign_d = req_sign;
          to_d   = 1'b0;
          if (spec_hit) begin
            q_d     = spec_q;
            flags_d = spec_flags;
            state_d = StResp;
          end else begin
            a_d       = req_a;
            recip_b_d = req_b;
            state_d   = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = flush ? StDrain : StWait;
      end
      StWait: begin
        if (flush) begin
          state_d = StDrain;
        end else if (recip_done) begin
          inv_d   = recip_inv;
          state_d = StMul;
        end else if (cnt_q == CntMax) begin
          q_d              = QNAN_CANON;
          flags_d          = '0;
          flags_d[FLAG_TO] = 1'b1;
          to_d             = 1'b1;
          state_d          = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StDrain;
        end else begin
          // Overwrite the product sign with a^b's sign.
          q_d     = mul_p ^ {mul_p[31] ^ sign_q, 31'h0};
          flags_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        // A timed-out op still owns the reciprocal unit until it reports done.
        if (flush || resp_ready) state_d = to_q ? StDrain : StIdle;
      end
      StDrain: begin
        if (recip_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      inv_q     <= '0;
      recip_b_q <= '0;
      q_q       <= '0;
      tag_q     <= '0;
      flags_q   <= '0;
      sign_q    <= 1'b0;
      to_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      inv_q     <= inv_d;
      recip_b_q <= recip_b_d;
      q_q       <= q_d;
      tag_q     <= tag_d;
      flags_q   <= flags_d;
      sign_q    <= sign_d;
      to_q      <= to_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign recip_start = (state_q == StIssue);
  assign resp_valid  = (state_q == StResp);
  assign recip_b     = recip_b_q;
  assign resp_q      = q_q;
  assign resp_tag    = tag_q;
  assign resp_flags  = flags_q;

endmodule
